// File: rtl/but_debounce_pkg.sv
// Shared types and default timing for the pushbutton debouncer.
// Cycle counts assume a 100 MHz CLK.
package but_debounce_pkg;

  typedef enum logic [1:0] {
    ST_RELEASED = 2'd0,
    ST_PRESSED  = 2'd1,
    ST_HELD     = 2'd2
  } ch_state_e;

  localparam int DEF_DEBOUNCE_CYCLES = 1000000;
  localparam int DEF_LONG_CYCLES     = 100000000;

endpackage

// File: rtl/but_debounce_ch.sv
// One debounce channel: 2-flop synchroniser, stability counter,
// long-press counter, state machine and registered strobes.
module but_debounce_ch
  import but_debounce_pkg::*;
#(
  parameter int DEB  = DEF_DEBOUNCE_CYCLES,
  parameter int LONG = DEF_LONG_CYCLES
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_but_n,
  output logic o_pressed,
  output logic o_press_stb,
  output logic o_release_stb,
  output logic o_long_stb
);

  localparam int CW = $clog2(DEB + 1);
  localparam int LW = $clog2(LONG + 1);

  logic          r_sync1;
  logic          r_sync2;
  ch_state_e     r_state;
  logic [CW-1:0] r_cnt;
  logic [LW-1:0] r_lcnt;
  logic          r_press_stb;
  logic          r_release_stb;
  logic          r_long_stb;

  ch_state_e     w_state_nx;
  logic [CW-1:0] w_cnt_nx;
  logic [LW-1:0] w_lcnt_nx;
  logic          w_press;
  logic          w_release;
  logic          w_long;
  logic          w_accept;
  logic          w_s;
  logic          w_lvl;

  assign w_s   = ~r_sync2;
  assign w_lvl = (r_state != ST_RELEASED);

  // State, counters, synchroniser and strobe registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1       <= 1'b1;
      r_sync2       <= 1'b1;
      r_state       <= ST_RELEASED;
      r_cnt         <= '0;
      r_lcnt        <= '0;
      r_press_stb   <= 1'b0;
      r_release_stb <= 1'b0;
      r_long_stb    <= 1'b0;
    end else begin
      r_sync1       <= i_but_n;
      r_sync2       <= r_sync1;
      r_state       <= w_state_nx;
      r_cnt         <= w_cnt_nx;
      r_lcnt        <= w_lcnt_nx;
      r_press_stb   <= w_press;
      r_release_stb <= w_release;
      r_long_stb    <= w_long;
    end
  end

  // Next-state: debounce acceptance, long-press timing, strobes
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = '0;
    w_lcnt_nx  = r_lcnt;
    w_press    = 1'b0;
    w_release  = 1'b0;
    w_long     = 1'b0;
    w_accept   = 1'b0;

    // A sample matching the level keeps the count at 0,
    // so any bounce back restarts it.
    if (w_s != w_lvl) begin
      if (r_cnt == CW'(DEB - 1)) begin
        w_accept = 1'b1;
      end else begin
        w_cnt_nx = r_cnt + CW'(1);
      end
    end

    unique case (r_state)
      ST_RELEASED: begin
        w_lcnt_nx = '0;
        if (w_accept) begin
          w_state_nx = ST_PRESSED;
          w_press    = 1'b1;
        end
      end
      ST_PRESSED: begin
        if (r_lcnt == LW'(LONG - 1)) begin
          w_long     = 1'b1;
          w_state_nx = ST_HELD;
          w_lcnt_nx  = LW'(LONG);
        end else begin
          w_lcnt_nx = r_lcnt + LW'(1);
        end
        // Release wins the state but the long strobe still fires.
        if (w_accept) begin
          w_state_nx = ST_RELEASED;
          w_release  = 1'b1;
          w_lcnt_nx  = '0;
        end
      end
      ST_HELD: begin
        if (w_accept) begin
          w_state_nx = ST_RELEASED;
          w_release  = 1'b1;
          w_lcnt_nx  = '0;
        end
      end
      default: begin
        w_state_nx = ST_RELEASED;
        w_lcnt_nx  = '0;
      end
    endcase
  end

  assign o_pressed     = w_lvl;
  assign o_press_stb   = r_press_stb;
  assign o_release_stb = r_release_stb;
  assign o_long_stb    = r_long_stb;

endmodule

// File: rtl/but_debounce.sv
// N-channel active-low pushbutton debouncer with press,
// release and long-press strobes.
module but_debounce
  import but_debounce_pkg::*;
#(
  parameter int N_BUT           = 2,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int LONG_CYCLES     = DEF_LONG_CYCLES
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [N_BUT-1:0] BUT_N,
  output logic [N_BUT-1:0] PRESSED,
  output logic [N_BUT-1:0] PRESS_STB,
  output logic [N_BUT-1:0] RELEASE_STB,
  output logic [N_BUT-1:0] LONG_STB
);

  // One independent channel per button
  for (genvar g = 0; g < N_BUT; g++) begin : g_ch
    but_debounce_ch #(
      .DEB  (DEBOUNCE_CYCLES),
      .LONG (LONG_CYCLES)
    ) u_ch (
      .i_clk         (CLK),
      .i_rst         (RST),
      .i_but_n       (BUT_N[g]),
      .o_pressed     (PRESSED[g]),
      .o_press_stb   (PRESS_STB[g]),
      .o_release_stb (RELEASE_STB[g]),
      .o_long_stb    (LONG_STB[g])
    );
  end

endmodule

// File: tb/tb_but_debounce.sv
// Bench for but_debounce: table of button steps plus hand
// sequences; strobes are matched against a cycle-stamped queue.
module tb_but_debounce;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] but_n;
  logic [1:0] pressed;
  logic [1:0] press_stb;
  logic [1:0] release_stb;
  logic [1:0] long_stb;

  but_debounce #(
    .N_BUT           (2),
    .DEBOUNCE_CYCLES (4),
    .LONG_CYCLES     (10)
  ) dut (
    .CLK         (clk),
    .RST         (rst),
    .BUT_N       (but_n),
    .PRESSED     (pressed),
    .PRESS_STB   (press_stb),
    .RELEASE_STB (release_stb),
    .LONG_STB    (long_stb)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [1:0] p;
    logic [1:0] r;
    logic [1:0] l;
  } exp_t;

  typedef struct {
    logic [1:0] but_n;
    int         hold;
    logic [1:0] p;
    logic [1:0] r;
    logic [1:0] l;
    int         lofs;
    logic [1:0] pr;
  } row_t;

  exp_t q[$];
  row_t tbl[9];
  int   n_cmp = 0;
  int   n_err = 0;
  bit   mon_en = 0;

  // Pin change driven at cycle c shows its strobe at c + 6.
  localparam int LAT = 6;

  task automatic push_exp(input int c, input logic [1:0] p,
                          input logic [1:0] r, input logic [1:0] l);
    exp_t e;
    int   idx;
    idx = q.size();
    for (int i = 0; i < q.size(); i++) begin
      if (q[i].cyc == c) begin
        q[i].p |= p;
        q[i].r |= r;
        q[i].l |= l;
        return;
      end
      if (q[i].cyc > c && idx == q.size()) idx = i;
    end
    e.cyc = c;
    e.p   = p;
    e.r   = r;
    e.l   = l;
    q.insert(idx, e);
  endtask

  task automatic monitor();
    exp_t e;
    if (!mon_en) return;
    while (q.size() > 0 && q[0].cyc < cyc) begin
      n_cmp++;
      n_err++;
      $display("FAIL missed_strobe cyc=%0d: got none, want p=%b r=%b l=%b at cyc %0d",
               cyc, q[0].p, q[0].r, q[0].l, q[0].cyc);
      void'(q.pop_front());
    end
    if ((press_stb | release_stb | long_stb) != 2'b00) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_strobe cyc=%0d: got p=%b r=%b l=%b, want none",
                 cyc, press_stb, release_stb, long_stb);
      end else begin
        e = q.pop_front();
        if (e.cyc != cyc || e.p != press_stb ||
            e.r != release_stb || e.l != long_stb) begin
          n_err++;
          $display("FAIL strobe cyc=%0d: got p=%b r=%b l=%b, want p=%b r=%b l=%b at cyc %0d",
                   cyc, press_stb, release_stb, long_stb, e.p, e.r, e.l, e.cyc);
        end
      end
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      monitor();
    end
  endtask

  task automatic chk(input string nm, input logic [1:0] got,
                     input logic [1:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s cyc=%0d: got %b, want %b", nm, cyc, got, want);
    end
  endtask

  initial begin
    tbl[0] = '{2'b10,  8, 2'b01, 2'b00, 2'b00,  0, 2'b01};
    tbl[1] = '{2'b11,  8, 2'b00, 2'b01, 2'b00,  0, 2'b00};
    tbl[2] = '{2'b01, 40, 2'b10, 2'b00, 2'b10, 16, 2'b10};
    tbl[3] = '{2'b11,  8, 2'b00, 2'b10, 2'b00,  0, 2'b00};
    tbl[4] = '{2'b00,  8, 2'b11, 2'b00, 2'b00,  0, 2'b11};
    tbl[5] = '{2'b11,  8, 2'b00, 2'b11, 2'b00,  0, 2'b00};
    tbl[6] = '{2'b10, 10, 2'b01, 2'b00, 2'b01, 16, 2'b01};
    tbl[7] = '{2'b11,  8, 2'b00, 2'b01, 2'b00,  0, 2'b00};
    tbl[8] = '{2'b10,  9, 2'b01, 2'b00, 2'b00,  0, 2'b01};

    rst   = 1'b1;
    but_n = 2'b11;
    step(3);
    rst = 1'b0;
    chk("rst_pressed", pressed, 2'b00);
    chk("rst_press_stb", press_stb, 2'b00);
    chk("rst_release_stb", release_stb, 2'b00);
    chk("rst_long_stb", long_stb, 2'b00);
    mon_en = 1;
    step(2);

    for (int i = 0; i < 9; i++) begin
      but_n = tbl[i].but_n;
      if ((tbl[i].p | tbl[i].r) != 2'b00)
        push_exp(cyc + LAT, tbl[i].p, tbl[i].r, 2'b00);
      if (tbl[i].l != 2'b00)
        push_exp(cyc + tbl[i].lofs, 2'b00, 2'b00, tbl[i].l);
      step(tbl[i].hold);
      chk($sformatf("row%0d_pressed", i), pressed, tbl[i].pr);
    end

    // Release after row 8: one cycle short of the long press.
    but_n = 2'b11;
    push_exp(cyc + LAT, 2'b00, 2'b01, 2'b00);
    step(10);
    chk("short_rel_pressed", pressed, 2'b00);

    // Bounce on channel 0, two cycles per level, then steady.
    for (int k = 0; k < 4; k++) begin
      but_n = (k % 2 == 0) ? 2'b10 : 2'b11;
      step(2);
      chk($sformatf("bounce%0d_pressed", k), pressed, 2'b00);
    end
    but_n = 2'b10;
    push_exp(cyc + LAT, 2'b01, 2'b00, 2'b00);
    step(5);
    chk("bounce_pre_accept", pressed, 2'b00);
    step(3);
    chk("bounce_pressed", pressed, 2'b01);
    but_n = 2'b11;
    push_exp(cyc + LAT, 2'b00, 2'b01, 2'b00);
    step(10);

    // Reset while channel 0 is pressed and the pin stays low.
    but_n = 2'b10;
    push_exp(cyc + LAT, 2'b01, 2'b00, 2'b00);
    step(8);
    chk("pre_rst_pressed", pressed, 2'b01);
    rst = 1'b1;
    step(1);
    chk("midrst_pressed", pressed, 2'b00);
    chk("midrst_release_stb", release_stb, 2'b00);
    chk("midrst_press_stb", press_stb, 2'b00);
    chk("midrst_long_stb", long_stb, 2'b00);
    rst = 1'b0;
    push_exp(cyc + LAT, 2'b01, 2'b00, 2'b00);
    step(5);
    chk("post_rst_wait", pressed, 2'b00);
    step(3);
    chk("post_rst_pressed", pressed, 2'b01);
    but_n = 2'b11;
    push_exp(cyc + LAT, 2'b00, 2'b01, 2'b00);
    step(30);
    chk("final_pressed", pressed, 2'b00);

    n_cmp++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL queue_drain: got %0d pending, want 0", q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
